// File: rtl/dm_access_seq_pkg.sv
// Shared definitions for the data-memory access sequencer: DMType codes,
// sequencer states, lane masks and request legality helpers.
package dm_access_seq_pkg;

   typedef enum logic [2:0] {
      dm_word          = 3'b000,
      dm_half          = 3'b001,
      dm_half_unsigned = 3'b010,
      dm_byte          = 3'b011,
      dm_byte_unsigned = 3'b100
   } dm_type_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_DONE
   } dm_state_e;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

   // Legal = known type and natural alignment for its size.
   function automatic logic dm_legal(input logic [2:0] t, input logic [1:0] a);
      logic ok;
      ok = 1'b0;
      case (t)
         dm_word:                    ok = (a == 2'b00);
         dm_half, dm_half_unsigned:  ok = ~a[0];
         dm_byte, dm_byte_unsigned:  ok = 1'b1;
         default:                    ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Sub-word accesses need the old word, so stores of this kind go through RD.
   function automatic logic dm_is_subword(input logic [2:0] t);
      return (t != dm_word);
   endfunction

endpackage

// File: rtl/dm_lane.sv
// Combinational lane logic: load extraction with sign/zero extension and
// sub-word store merge into the previously read RAM word.
module dm_lane
   import dm_access_seq_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [15:0] i_wdata,
   input  logic [2:0]  i_type,
   input  logic [1:0]  i_off,
   output logic [31:0] o_load,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [4:0]  w_bsh;
   logic [4:0]  w_hsh;

   assign w_bsh  = {i_off, 3'b000};
   assign w_hsh  = {i_off[1], 4'b0000};
   assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

   // Select the addressed byte lane.
   always_comb begin
      w_byte = i_word[7:0];
      case (i_off)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
   end

   // Extend the selected lane to 32 bits according to the load type.
   always_comb begin
      o_load = i_word;
      case (i_type)
         dm_half:          o_load = {{16{w_half[15]}}, w_half};
         dm_half_unsigned: o_load = {16'h0000, w_half};
         dm_byte:          o_load = {{24{w_byte[7]}}, w_byte};
         dm_byte_unsigned: o_load = {24'h00_0000, w_byte};
         default:          o_load = i_word;
      endcase
   end

   // Replace the addressed lane of the old word with the store data.
   always_comb begin
      o_merged = i_word;
      case (i_type)
         dm_half, dm_half_unsigned:
            o_merged = (i_word & ~(HALF_MASK << w_hsh)) | ({16'h0000, i_wdata} << w_hsh);
         dm_byte, dm_byte_unsigned:
            o_merged = (i_word & ~(BYTE_MASK << w_bsh)) | ({24'h00_0000, i_wdata[7:0]} << w_bsh);
         default:
            o_merged = i_word;
      endcase
   end

endmodule

// File: rtl/dm_access_seq.sv
// MEM-stage data-memory access sequencer: loads with extension, word stores,
// and sub-word stores as read-modify-write against a word-only RAM.
module dm_access_seq
   import dm_access_seq_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [2:0]    req_type,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          stall,
   output logic          done,
   output logic          fault,
   output logic [31:0]   rdata,
   output logic [AW-3:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   dm_state_e     r_state;
   logic [1:0]    r_off;
   logic [2:0]    r_type;
   logic          r_we;
   logic [15:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic [AW-3:0] r_mem_addr;
   logic          r_mem_re;
   logic          r_mem_we;
   logic [31:0]   r_mem_wdata;
   logic          r_done;

   logic          w_legal;
   logic          w_idle_req;
   logic          w_accept;
   logic [31:0]   w_load;
   logic [31:0]   w_merged;

   assign w_legal    = dm_legal(req_type, req_addr[1:0]);
   assign w_idle_req = (r_state == S_IDLE) && req_valid;
   assign w_accept   = w_idle_req && w_legal;

   assign fault = w_idle_req && !w_legal;
   assign stall = w_accept || (r_state == S_RD) || (r_state == S_CAP) || (r_state == S_WR);

   assign done      = r_done;
   assign rdata     = r_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_re    = r_mem_re;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;

   dm_lane u_lane (
      .i_word   (mem_rdata),
      .i_wdata  (r_wdata),
      .i_type   (r_type),
      .i_off    (r_off),
      .o_load   (w_load),
      .o_merged (w_merged)
   );

   // Sequencer FSM with registered RAM strobes, load data and retire pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_off       <= 2'b00;
         r_type      <= 3'b000;
         r_we        <= 1'b0;
         r_wdata     <= 16'h0000;
         r_rdata     <= 32'h0000_0000;
         r_mem_addr  <= '0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= 32'h0000_0000;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_off      <= req_addr[1:0];
                  r_type     <= req_type;
                  r_we       <= req_we;
                  r_wdata    <= req_wdata[15:0];
                  r_mem_addr <= req_addr[AW-1:2];
                  if (!req_we || dm_is_subword(req_type)) begin
                     r_mem_re <= 1'b1;
                     r_state  <= S_RD;
                  end else begin
                     r_mem_we    <= 1'b1;
                     r_mem_wdata <= req_wdata;
                     r_state     <= S_WR;
                  end
               end
            end
            S_RD: begin
               r_mem_re <= 1'b0;
               r_state  <= S_CAP;
            end
            S_CAP: begin
               if (!r_we) begin
                  r_rdata <= w_load;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_mem_wdata <= w_merged;
                  r_mem_we    <= 1'b1;
                  r_state     <= S_WR;
               end
            end
            S_WR: begin
               r_mem_we <= 1'b0;
               r_done   <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
